// File: rtl/freq_bcd_counter_if.sv
// Measurement-side signals of the frequency counter: input under test and latched BCD result.
// The master modport is the counter; the slave modport is whoever consumes the result.
interface freq_bcd_counter_if;
    logic       sig_in;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       overflow;
    logic       valid;
    logic       gate;

    modport master (
        input  sig_in,
        output digit0, digit1, digit2, digit3, overflow, valid, gate
    );

    modport slave (
        output sig_in,
        input  digit0, digit1, digit2, digit3, overflow, valid, gate
    );
endinterface

// File: rtl/freq_bcd_counter.sv
// Gated frequency counter: counts sig_in rising edges over a GATE_CYCLES window into a saturating
// 4-decade BCD counter, then latches the result and strobes valid once per window.
module freq_bcd_counter #(
    parameter int unsigned GATE_CYCLES = 100000000
) (
    input  logic                  clock,
    input  logic                  reset,
    freq_bcd_counter_if.master    bus
);

    typedef enum logic [0:0] {StRun, StDone} state_e;

    localparam logic [26:0] TimerLast = 27'(GATE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [26:0]     timer_q, timer_d;
    logic            sync1_q, sync2_q, hist_q;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic            sticky_q, sticky_d;
    logic [3:0][3:0] digit_q;
    logic            overflow_q;
    logic            valid_q;
    logic            edge_det;
    logic            carry;

    assign edge_det = sync2_q & ~hist_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StRun: begin
                if (timer_q == TimerLast) begin
                    state_d = StDone;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 27'd1;
                end
            end
            StDone:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Counter is cleared throughout DONE, which also drops any edge detected there.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        carry    = 1'b0;
        if (state_q == StDone) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (edge_det) begin
            if (cnt_q == 16'h9999) begin
                sticky_d = 1'b1;
            end else begin
                carry = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (carry) begin
                        if (cnt_q[i] == 4'd9) begin
                            cnt_d[i] = 4'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StRun;
            timer_q    <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            digit_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sync1_q  <= bus.sig_in;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            valid_q  <= (state_q == StDone);
            if (state_q == StDone) begin
                digit_q    <= cnt_q;
                overflow_q <= sticky_q;
            end
        end
    end

    assign bus.digit0   = digit_q[0];
    assign bus.digit1   = digit_q[1];
    assign bus.digit2   = digit_q[2];
    assign bus.digit3   = digit_q[3];
    assign bus.overflow = overflow_q;
    assign bus.valid    = valid_q;
    assign bus.gate     = (state_q == StRun);

endmodule

// File: tb/tb_freq_bcd_counter.sv
// Directed bench for freq_bcd_counter: three instances (gate 100, 4000, 25000) exercised in turn.
module tb_freq_bcd_counter;

    logic        clock = 1'b0;
    logic [2:0]  rst_v = 3'b111;
    logic [2:0]  sig_v = 3'b000;
    logic [15:0] digs [3];
    logic        ovf [3];
    logic        vld [3];
    logic        gt  [3];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    freq_bcd_counter_if if0 ();
    freq_bcd_counter_if if1 ();
    freq_bcd_counter_if if2 ();

    assign if0.sig_in = sig_v[0];
    assign if1.sig_in = sig_v[1];
    assign if2.sig_in = sig_v[2];

    freq_bcd_counter #(.GATE_CYCLES(100))   u_g100   (.clock(clock), .reset(rst_v[0]), .bus(if0));
    freq_bcd_counter #(.GATE_CYCLES(4000))  u_g4000  (.clock(clock), .reset(rst_v[1]), .bus(if1));
    freq_bcd_counter #(.GATE_CYCLES(25000)) u_g25000 (.clock(clock), .reset(rst_v[2]), .bus(if2));

    assign digs[0] = {if0.digit3, if0.digit2, if0.digit1, if0.digit0};
    assign digs[1] = {if1.digit3, if1.digit2, if1.digit1, if1.digit0};
    assign digs[2] = {if2.digit3, if2.digit2, if2.digit1, if2.digit0};
    assign ovf[0] = if0.overflow;
    assign ovf[1] = if1.overflow;
    assign ovf[2] = if2.overflow;
    assign vld[0] = if0.valid;
    assign vld[1] = if1.valid;
    assign vld[2] = if2.valid;
    assign gt[0]  = if0.gate;
    assign gt[1]  = if1.gate;
    assign gt[2]  = if2.gate;

    typedef struct {
        int          n;
        int          period;
        int          offset;
        logic [15:0] exp_d;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold reset for a few cycles, check reset outputs, release; caller is then at window cycle 0.
    task automatic do_reset(input int idx, input string name);
        rst_v[idx] = 1'b1;
        step();
        step();
        check({name, " rst digits"}, 32'(digs[idx]), 32'h0);
        check({name, " rst overflow"}, 32'(ovf[idx]), 32'h0);
        check({name, " rst valid"}, 32'(vld[idx]), 32'h0);
        check({name, " rst gate"}, 32'(gt[idx]), 32'h1);
        rst_v[idx] = 1'b0;
    endtask

    // Starts at window cycle 0; pulses sig_in (if n>0) and ends on the valid cycle.
    task automatic run_window(input int idx, input int gate_len, input int n, input int period,
                              input int offset, input logic [15:0] exp_d, input logic exp_ovf,
                              input string name);
        int  lat;
        int  low;
        int  k;
        bit  seen;
        lat  = 0;
        low  = 0;
        seen = 1'b0;
        for (int t = 0; t <= gate_len + 20; t++) begin
            if (t > 0 && vld[idx]) begin
                seen = 1'b1;
                lat  = t;
                break;
            end
            if (!gt[idx]) low++;
            if (n > 0) begin
                k = t - offset;
                sig_v[idx] = (k >= 0) && (k % period == 0) && (k / period < n);
            end
            step();
        end
        if (!seen) begin
            check({name, " valid timeout"}, 32'h0, 32'h1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(gate_len + 1));
            check({name, " digits"}, 32'(digs[idx]), 32'(exp_d));
            check({name, " overflow"}, 32'(ovf[idx]), 32'(exp_ovf));
            check({name, " gate low cycles"}, 32'(low), 32'h1);
        end
    endtask

    initial begin
        vecs[0] = '{n: 37, period: 2, offset: 0,  exp_d: 16'h0037, exp_ovf: 1'b0, name: "p37"};
        vecs[1] = '{n: 0,  period: 2, offset: 0,  exp_d: 16'h0000, exp_ovf: 1'b0, name: "idle"};
        vecs[2] = '{n: 5,  period: 3, offset: 0,  exp_d: 16'h0005, exp_ovf: 1'b0, name: "p5"};
        vecs[3] = '{n: 33, period: 3, offset: 0,  exp_d: 16'h0033, exp_ovf: 1'b0, name: "p33"};
        vecs[4] = '{n: 49, period: 2, offset: 0,  exp_d: 16'h0049, exp_ovf: 1'b0, name: "p49"};
        vecs[5] = '{n: 1,  period: 1, offset: 98, exp_d: 16'h0000, exp_ovf: 1'b0, name: "edge_in_done"};
        vecs[6] = '{n: 1,  period: 1, offset: 97, exp_d: 16'h0001, exp_ovf: 1'b0, name: "edge_on_last_run"};

        do_reset(0, "g100");
        for (int i = 0; i < 7; i++) begin
            run_window(0, 100, vecs[i].n, vecs[i].period, vecs[i].offset, vecs[i].exp_d,
                       vecs[i].exp_ovf, vecs[i].name);
        end

        // Mid-window reset: 20 pulses, reset at cycle 50 discards them and clears the 0001 result.
        for (int t = 0; t < 50; t++) begin
            sig_v[0] = (t % 2 == 0) && (t / 2 < 20);
            step();
        end
        sig_v[0] = 1'b0;
        rst_v[0] = 1'b1;
        step();
        check("midrst digits", 32'(digs[0]), 32'h0);
        check("midrst valid", 32'(vld[0]), 32'h0);
        check("midrst gate", 32'(gt[0]), 32'h1);
        rst_v[0] = 1'b0;
        run_window(0, 100, 3, 2, 0, 16'h0003, 1'b0, "post_midrst");

        // Reset landing on the DONE cycle must suppress that window's strobe.
        for (int t = 0; t < 100; t++) begin
            sig_v[0] = (t % 3 == 0) && (t / 3 < 4);
            step();
        end
        check("done cycle gate", 32'(gt[0]), 32'h0);
        rst_v[0] = 1'b1;
        step();
        check("done rst valid", 32'(vld[0]), 32'h0);
        check("done rst digits", 32'(digs[0]), 32'h0);
        check("done rst gate", 32'(gt[0]), 32'h1);
        rst_v[0] = 1'b0;
        run_window(0, 100, 2, 3, 0, 16'h0002, 1'b0, "post_done_rst");

        // sig_in high across reset release counts once.
        sig_v[0] = 1'b1;
        do_reset(0, "level");
        run_window(0, 100, 0, 1, 0, 16'h0001, 1'b0, "level_w1");
        run_window(0, 100, 0, 1, 0, 16'h0000, 1'b0, "level_w2");
        sig_v[0] = 1'b0;
        step();
        check("valid one cycle", 32'(vld[0]), 32'h0);
        rst_v[0] = 1'b1;

        do_reset(1, "g4000");
        run_window(1, 4000, 1000, 3, 0, 16'h1000, 1'b0, "carry_1000");
        run_window(1, 4000, 999, 3, 0, 16'h0999, 1'b0, "carry_999");
        rst_v[1] = 1'b1;

        do_reset(2, "g25000");
        run_window(2, 25000, 12500, 2, 0, 16'h9999, 1'b1, "saturate");
        run_window(2, 25000, 5, 3, 0, 16'h0005, 1'b0, "after_sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
